debug_trace_buf: RTL and testbench

DEBUG_TRACE_BUF -- requirements
Module: debug_trace_buf

---
 rtl/debug_trace_buf.sv | 155 +++++++++++++++
 tb/tb_debug_trace_buf.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_buf.sv
// Triggered trace capture buffer: records one selected channel into a circular
// store around a masked-compare trigger, then plays the held window back oldest-first.
module debug_trace_buf #(
    parameter int BUS_WIDTH = 64,
    parameter int DEPTH     = 16,
    parameter int CHANNELS  = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*BUS_WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]           ch_valid,
    input  logic [SW-1:0]                 ch_sel,
    input  logic                          arm,
    input  logic [BUS_WIDTH-1:0]          trig_value,
    input  logic [BUS_WIDTH-1:0]          trig_mask,
    input  logic [AW:0]                   post_count,
    input  logic                          rd_en,
    output logic [BUS_WIDTH-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          busy,
    output logic                          done,
    output logic [AW:0]                   count
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t                 state_q, state_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [AW:0]            count_q, count_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic [AW:0]            post_q, post_d;
    logic [AW:0]            rem_q, rem_d;
    logic [BUS_WIDTH-1:0]   rd_data_q;
    logic                   rd_valid_q;
    logic                   wr_en;
    logic                   rd_fire;
    logic                   start;

    logic [BUS_WIDTH-1:0]   mem [DEPTH];
    logic [BUS_WIDTH-1:0]   ch_word [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign ch_word[gi] = ch_data[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    logic [BUS_WIDTH-1:0] sample_word;
    logic                 sample_vld;
    logic                 trig_hit;

    assign sample_word = ch_word[sel_q];
    assign sample_vld  = ch_valid[sel_q];
    assign trig_hit    = ((sample_word ^ trig_value) & trig_mask) == '0;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        sel_d   = sel_q;
        post_d  = post_q;
        rem_d   = rem_q;
        wr_en   = 1'b0;
        rd_fire = 1'b0;
        start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) start = 1'b1;
            end
            ARMED, POST: begin
                if (sample_vld) begin
                    wr_en   = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
                    if (state_q == ARMED) begin
                        if (trig_hit) begin
                            if (post_q == '0) begin
                                state_d = DONE;
                            end else begin
                                state_d = POST;
                                rem_d   = post_q;
                            end
                        end
                    end else begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == (AW+1)'(1)) state_d = DONE;
                    end
                    // Oldest held entry sits count entries behind the next write slot.
                    rptr_d = wptr_d - count_d[AW-1:0];
                end
            end
            DONE: begin
                if (arm) begin
                    start = 1'b1;
                end else if (rd_en && count_q != '0) begin
                    rd_fire = 1'b1;
                    rptr_d  = rptr_q + 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = ARMED;
            wptr_d  = '0;
            count_d = '0;
            sel_d   = (32'(ch_sel) >= CHANNELS) ? '0 : ch_sel;
            post_d  = post_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            sel_q      <= '0;
            post_q     <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            sel_q      <= sel_d;
            post_q     <= post_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_data_q <= mem[rptr_q];
        end
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= sample_word;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == ARMED) || (state_q == POST);
    assign done     = (state_q == DONE);
    assign count    = count_q;

endmodule

// File: tb/tb_debug_trace_buf.sv
// Bench for debug_trace_buf: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a queue-based model of the capture window.
module tb_debug_trace_buf;

    localparam int BW    = 64;
    localparam int DEPTH = 16;
    localparam int CH    = 2;
    localparam int AW    = 4;
    localparam int SW    = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH*BW-1:0]     ch_data;
    logic [CH-1:0]        ch_valid;
    logic [SW-1:0]        ch_sel;
    logic                 arm;
    logic [BW-1:0]        trig_value;
    logic [BW-1:0]        trig_mask;
    logic [AW:0]          post_count;
    logic                 rd_en;
    logic [BW-1:0]        rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 done;
    logic [AW:0]          count;

    debug_trace_buf #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
        .ch_sel(ch_sel), .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask),
        .post_count(post_count), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 idle, 1 armed, 2 post-trigger, 3 done; m_q holds the window oldest-first.
    int          m_mode;
    logic [BW-1:0] m_q[$];
    int          m_sel, m_post, m_rem;
    logic        m_rv;
    logic [BW-1:0] m_rd;

    task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_sel = 0; m_post = 0; m_rem = 0;
        m_rv = 1'b0; m_rd = '0;
    endtask

    task automatic model_start();
        m_mode = 1;
        m_q.delete();
        m_sel  = (int'(ch_sel) >= CH) ? 0 : int'(ch_sel);
        m_post = int'(post_count);
    endtask

    task automatic model_step();
        logic [BW-1:0] w;
        m_rv = 1'b0;
        case (m_mode)
            0: if (arm) model_start();
            1, 2: begin
                w = ch_data[m_sel*BW +: BW];
                if (ch_valid[m_sel]) begin
                    m_q.push_back(w);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                    if (m_mode == 1) begin
                        if (((w ^ trig_value) & trig_mask) == '0) begin
                            if (m_post == 0) m_mode = 3;
                            else begin m_mode = 2; m_rem = m_post; end
                        end
                    end else begin
                        m_rem--;
                        if (m_rem == 0) m_mode = 3;
                    end
                end
            end
            default: begin
                if (arm) model_start();
                else if (rd_en && m_q.size() > 0) begin
                    m_rv = 1'b1;
                    m_rd = m_q.pop_front();
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("busy",     BW'(busy),     BW'(m_mode == 1 || m_mode == 2));
        check_val("done",     BW'(done),     BW'(m_mode == 3));
        check_val("count",    BW'(count),    BW'(m_q.size()));
        check_val("rd_valid", BW'(rd_valid), BW'(m_rv));
        check_val("rd_data",  rd_data,       m_rd);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        arm = 1'b0; rd_en = 1'b0; ch_valid = '0;
        ch_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_ch(input int k, input logic [BW-1:0] d);
        ch_data[k*BW +: BW] = d;
    endtask

    task automatic hit_reset();
        idle_in();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic arm_cfg(input int s, input logic [BW-1:0] val, input logic [BW-1:0] mask, input int pc);
        idle_in();
        arm = 1'b1; ch_sel = SW'(s); trig_value = val; trig_mask = mask;
        post_count = (AW+1)'(pc);
        tick();
        arm = 1'b0;
    endtask

    task automatic feed_036(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            ch_valid = 2'b10;
            set_ch(1, 64'h50 + 64'(i));
            tick();
        end
    endtask

    task automatic read_036(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            rd_en = 1'b1;
            tick();
            if (i < 9) check_val("r036_rd", rd_data, 64'h50 + 64'(i));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt;
        int guard;
        rst = 1'b1; ch_sel = '0; trig_value = '0; trig_mask = '0; post_count = '0;
        idle_in();
        model_reset();
        @(posedge clk); #1;
        compare_all();
        @(posedge clk); #1;
        rst = 1'b0;
        // Reads with nothing captured must never fire.
        for (int i = 0; i < 3; i++) begin idle_in(); rd_en = 1'b1; tick(); end

        // Basic trigger window
        arm_cfg(1, 64'h55, '1, 3);
        feed_036(12);
        check_val("r036_count", BW'(count), 64'd9);
        read_036(10);
        check_val("r036_empty", BW'(count), 64'd0);

        // Circular wrap: trigger sample itself is overwritten
        arm_cfg(0, 64'hAAAA_0000, '1, 16);
        for (int i = 0; i < 47; i++) begin
            idle_in();
            ch_valid = 2'b01;
            if (i < 30)       set_ch(0, 64'(i));
            else if (i == 30) set_ch(0, 64'hAAAA_0000);
            else              set_ch(0, 64'h100 + 64'(i - 31));
            tick();
        end
        check_val("r037_count", BW'(count), 64'd16);
        rv_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            idle_in(); rd_en = 1'b1; tick();
            if (rd_valid) rv_cnt++;
            if (i < 16) check_val("r037_rd", rd_data, 64'h100 + 64'(i));
        end
        check_val("r037_pulses", BW'(rv_cnt), 64'd16);

        // Mask zero, no post samples
        arm_cfg(0, 64'h1234, '0, 0);
        idle_in(); tick();
        idle_in(); ch_valid = 2'b01; set_ch(0, 64'hDEAD_BEEF); tick();
        check_val("r038_done", BW'(done), 64'd1);
        check_val("r038_count", BW'(count), 64'd1);
        idle_in(); rd_en = 1'b1; tick();
        check_val("r038_rd", rd_data, 64'hDEAD_BEEF);

        // Gapped selected valid, busy unselected channel
        arm_cfg(1, '1, '1, 8);
        guard = 0;
        while (!done && guard < 300) begin
            idle_in();
            ch_valid = 2'($urandom_range(0, 3));
            set_ch(1, 64'h200 + 64'(guard));
            if (guard == 20) begin ch_valid[1] = 1'b1; set_ch(1, '1); end
            tick();
            guard++;
        end
        check_val("r039_timeout", BW'(done), 64'd1);
        for (int i = 0; i < 20; i++) begin idle_in(); rd_en = 1'b1; tick(); end

        // Reset mid-POST, then mid-readout
        arm_cfg(1, 64'h55, '1, 3);
        feed_036(7);
        hit_reset();
        arm_cfg(1, 64'h55, '1, 3);
        feed_036(10);
        read_036(4);
        hit_reset();
        arm_cfg(1, 64'h55, '1, 3);
        feed_036(10);
        check_val("r040_count", BW'(count), 64'd9);
        read_036(10);

        // Arm ignored while capturing; arm beats rd_en in DONE
        arm_cfg(1, 64'h55, '1, 3);
        feed_036(7);
        idle_in(); arm = 1'b1; ch_sel = 1'b0; post_count = '0;
        ch_valid = 2'b10; set_ch(1, 64'h57); tick();
        idle_in(); ch_valid = 2'b10; set_ch(1, 64'h58); tick();
        check_val("r041_count", BW'(count), 64'd9);
        idle_in(); arm = 1'b1; rd_en = 1'b1; tick();
        check_val("r041_busy", BW'(busy), 64'd1);
        check_val("r041_rv", BW'(rd_valid), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) hit_reset();
            arm        = ($urandom_range(0, 29) == 0);
            ch_sel     = SW'($urandom_range(0, 1));
            trig_value = 64'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: trig_mask = '0;
                1: trig_mask = 64'h3;
                default: trig_mask = 64'hFF;
            endcase
            post_count = (AW+1)'($urandom_range(0, 16));
            ch_valid   = 2'($urandom_range(0, 3));
            ch_data    = {$urandom, $urandom, $urandom, $urandom};
            rd_en      = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
